// File: rtl/npc_exec_leaf.sv
// npc_exec_leaf: execution leaf bundle of the single-cycle NPC RV32 core.
//   - 32x32 integer register file, x0 hardwired to zero,
//     two combinational read ports, one synchronous write port
//   - 32-bit ALU (ADD only, selected by one-hot alu_op)
//   - 3-to-8 one-hot decoder for funct3
//
// Optional feature macro: RF_WRITE_BYPASS_EN
//   defined   : a same-cycle write to the addressed register is forwarded
//               to the read port (x0 never forwarded)
//   undefined : read-during-write returns the stored (old) value
//
// Ports
//   clk           in   clock, rising edge
//   reset         in   synchronous active-high; clears x1..x31
//   i_wen         in   register write enable
//   i_waddr[4:0]  in   write index
//   i_wdata[31:0] in   write data
//   i_raddr1/2    in   read indices (rs1/rs2)
//   o_rdata1/2    out  read data
//   i_alu_src1/2  in   ALU operands
//   i_alu_op[0:0] in   one-hot op select, bit 0 = ADD
//   o_alu_result  out  ALU result
//   i_funct3[2:0] in   funct3 field
//   o_funct3_d    out  one-hot decode of funct3
module npc_exec_leaf (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_wen,
  input  logic [4:0]  i_waddr,
  input  logic [31:0] i_wdata,
  input  logic [4:0]  i_raddr1,
  output logic [31:0] o_rdata1,
  input  logic [4:0]  i_raddr2,
  output logic [31:0] o_rdata2,
  input  logic [31:0] i_alu_src1,
  input  logic [31:0] i_alu_src2,
  input  logic [0:0]  i_alu_op,
  output logic [31:0] o_alu_result,
  input  logic [2:0]  i_funct3,
  output logic [7:0]  o_funct3_d
);

  // Only x1..x31 hold state; x0 exists solely as a constant read slot.
  logic [31:0] r_regs [1:31];
  logic [31:0] w_regs [32];
  logic        w_wr_ok;

  assign w_wr_ok   = i_wen && (i_waddr != 5'd0);
  assign w_regs[0] = '0;

  for (genvar g = 1; g < 32; g++) begin : g_reg
    always_ff @(posedge clk) begin
      if (reset)
        r_regs[g] <= '0;
      else if (w_wr_ok && (i_waddr == 5'(g)))
        r_regs[g] <= i_wdata;
    end
    assign w_regs[g] = r_regs[g];
  end

`ifdef RF_WRITE_BYPASS_EN
  // w_wr_ok already excludes x0, so a read of x0 is never forwarded.
  assign o_rdata1 = (w_wr_ok && (i_raddr1 == i_waddr)) ? i_wdata : w_regs[i_raddr1];
  assign o_rdata2 = (w_wr_ok && (i_raddr2 == i_waddr)) ? i_wdata : w_regs[i_raddr2];
`else
  assign o_rdata1 = w_regs[i_raddr1];
  assign o_rdata2 = w_regs[i_raddr2];
`endif

  // Carry out is dropped: result is modulo 2^32.
  assign o_alu_result = i_alu_op[0] ? (i_alu_src1 + i_alu_src2) : 32'd0;

  assign o_funct3_d = 8'd1 << i_funct3;

endmodule

// File: tb/tb_npc_exec_leaf.sv
module tb_npc_exec_leaf;
  logic        clk = 1'b0;
  logic        reset;
  logic        wen;
  logic [4:0]  waddr, raddr1, raddr2;
  logic [31:0] wdata, rdata1, rdata2;
  logic [31:0] src1, src2, alu_result;
  logic [0:0]  alu_op;
  logic [2:0]  funct3;
  logic [7:0]  funct3_d;

  int checks = 0;
  int failures = 0;

  // Architectural view of the register file: plain array of 32 words.
  logic [31:0] model [32];

  npc_exec_leaf dut (
    .clk(clk), .reset(reset),
    .i_wen(wen), .i_waddr(waddr), .i_wdata(wdata),
    .i_raddr1(raddr1), .o_rdata1(rdata1),
    .i_raddr2(raddr2), .o_rdata2(rdata2),
    .i_alu_src1(src1), .i_alu_src2(src2), .i_alu_op(alu_op),
    .o_alu_result(alu_result),
    .i_funct3(funct3), .o_funct3_d(funct3_d)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Value a read port should show right now, given the pending write.
  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 0) return 32'd0;
`ifdef RF_WRITE_BYPASS_EN
    if (wen && waddr != 0 && a == waddr) return wdata;
`endif
    return model[a];
  endfunction

  function automatic logic [31:0] exp_alu(input logic op, input logic [31:0] a, input logic [31:0] b);
    longint unsigned s;
    if (!op) return 32'd0;
    s = (longint'(a) + longint'(b)) % 64'h1_0000_0000;
    return s[31:0];
  endfunction

  task automatic set_rf(input logic r, input logic w, input logic [4:0] wa,
                        input logic [31:0] wd, input logic [4:0] a1, input logic [4:0] a2);
    reset = r; wen = w; waddr = wa; wdata = wd; raddr1 = a1; raddr2 = a2;
  endtask

  task automatic check_all(input string tag);
    #1;
    chk({tag, "_rd1"}, rdata1, exp_rd(raddr1));
    chk({tag, "_rd2"}, rdata2, exp_rd(raddr2));
    chk({tag, "_alu"}, alu_result, exp_alu(alu_op[0], src1, src2));
    chk({tag, "_dec"}, {24'd0, funct3_d}, 32'd1 << funct3);
  endtask

  // Advance one rising edge and apply its effect to the model.
  task automatic tick();
    @(posedge clk);
    if (reset) for (int i = 0; i < 32; i++) model[i] = 32'd0;
    else if (wen && waddr != 0) model[waddr] = wdata;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'hx;
    model[0] = 32'd0;
    src1 = 0; src2 = 0; alu_op = 1'b0; funct3 = 3'd0;
    set_rf(1, 0, 0, 0, 0, 0);
    tick(); tick();
    reset = 1'b0;

    // reset sweep
    for (int a = 0; a < 32; a++) begin
      raddr1 = 5'(a); raddr2 = 5'(31 - a); #1;
      chk("rst_sweep1", rdata1, 32'd0);
      chk("rst_sweep2", rdata2, 32'd0);
    end

    // x5 written then cleared by reset; simultaneous write to x3 lost
    set_rf(0, 1, 5, 32'h12345678, 5, 5); tick();
    chk("x5_wr", rdata1, 32'h12345678);
    set_rf(1, 1, 3, 32'h7, 5, 3); tick();
    reset = 1'b0; wen = 1'b0; #1;
    chk("x5_rst", rdata1, 32'd0);
    chk("x3_rst_prio", rdata2, 32'd0);
    for (int a = 0; a < 32; a++) begin
      raddr1 = 5'(a); #1;
      chk("rst_sweep_b", rdata1, 32'd0);
    end

    // write/read both ports same register
    set_rf(0, 1, 10, 32'hDEADBEEF, 0, 0); tick();
    set_rf(0, 0, 0, 0, 10, 10); #1;
    chk("x10_p1", rdata1, 32'hDEADBEEF);
    chk("x10_p2", rdata2, 32'hDEADBEEF);

    // x0 write discarded
    set_rf(0, 1, 0, 32'hFFFFFFFF, 0, 0); tick();
    wen = 1'b0; #1;
    chk("x0_zero", rdata1, 32'd0);

    // write disable
    set_rf(0, 1, 3, 32'h55, 3, 3); tick();
    set_rf(0, 0, 3, 32'h7, 3, 3); tick();
    chk("wen0_hold", rdata1, 32'h55);
    set_rf(1, 1, 3, 32'h9, 3, 3); tick();
    reset = 1'b0; wen = 1'b0; #1;
    chk("rst_prio_x3", rdata1, 32'd0);

    // read-during-write
    set_rf(0, 1, 7, 32'd1, 7, 7); tick();
    set_rf(0, 1, 7, 32'd2, 7, 0); #1;
`ifdef RF_WRITE_BYPASS_EN
    chk("rdw_pre", rdata1, 32'd2);
`else
    chk("rdw_pre", rdata1, 32'd1);
`endif
    tick();
    wen = 1'b0; #1;
    chk("rdw_post", rdata1, 32'd2);

    // ALU directed
    alu_op = 1'b1; src1 = 32'h80000000; src2 = 32'hFFFFFFFC; #1;
    chk("alu_wrap1", alu_result, 32'h7FFFFFFC);
    src1 = 32'hFFFFFFFF; src2 = 32'h1; #1;
    chk("alu_wrap2", alu_result, 32'h0);
    alu_op = 1'b0; src1 = 32'h1234; src2 = 32'h5678; #1;
    chk("alu_off", alu_result, 32'h0);

    // decoder sweep
    for (int f = 0; f < 8; f++) begin
      funct3 = 3'(f); #1;
      chk("dec_sweep", {24'd0, funct3_d}, 32'h1 << f);
    end

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      set_rf(($urandom_range(0, 31) == 0), $urandom_range(0, 1),
             5'($urandom_range(0, 31)), $urandom, 5'($urandom_range(0, 31)),
             5'($urandom_range(0, 31)));
      if ($urandom_range(0, 3) == 0) raddr1 = waddr;
      alu_op = 1'($urandom_range(0, 3) != 0);
      src1 = $urandom; src2 = $urandom;
      if ($urandom_range(0, 7) == 0) src2 = ~src1 + 32'd1;
      funct3 = 3'($urandom_range(0, 7));
      check_all("rand");
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/npc_exec_leaf.md
# npc_exec_leaf

Combinational/sequential leaf bundle of the single-cycle NPC RV32 core: a 32×32 integer register file (two asynchronous read ports, one synchronous write port), a 32-bit ALU, and a 3-to-8 one-hot decoder for `funct3`. It sits between the instruction decoder and the writeback mux. The core feeds it register addresses, operands, `alu_op` and `funct3`. It returns register operands, the ALU result and the decoded `funct3`.

## Interface
- No parameters; all widths fixed (XLEN = 32, 32 registers).
- `clk` input 1: clock, all state updates on rising edge.
- `reset` input 1: reset, synchronous, active-high; clock clk.
- `wen` input 1: register write enable.
- `waddr` input 5: write register index.
- `wdata` input 32: write data.
- `raddr1` input 5: read port 1 index (rs1).
- `rdata1` output 32: read port 1 data.
- `raddr2` input 5: read port 2 index (rs2).
- `rdata2` output 32: read port 2 data.
- `alu_src1` input 32: ALU operand A.
- `alu_src2` input 32: ALU operand B.
- `alu_op` input 1: one-hot ALU operation select; bit 0 = ADD.
- `alu_result` output 32: ALU result.
- `funct3` input 3: instruction funct3 field.
- `funct3_d` output 8: one-hot decode of `funct3`.

## Operation
- **Register file storage**
  - Registers x1..x31 are real storage.
  - x0 is hardwired to zero: it always reads 0, and writes to index 0 are discarded.
- **Write**
  - When `wen`=1 and `waddr`≠0, `wdata` is stored into `waddr` at the rising edge.
  - When `wen`=0, the register file is unchanged.
- **Read**
  - `rdata1` and `rdata2` are purely combinational functions of their address and the current contents.
  - Both ports may address the same register simultaneously.
- **ALU**
  - `alu_op[0]`=1: `alu_result = alu_src1 + alu_src2`, modulo 2^32; carry is discarded and there is no overflow flag.
  - `alu_op[0]`=0: `alu_result = 0`.
  - The ALU is purely combinational.
- **Decoder**
  - `funct3_d = 8'b1 << funct3`. Exactly one bit is set for every input value.
  - The decoder is purely combinational.
- **Reset**
  - When `reset`=1 at a rising edge, x1..x31 are cleared to 0.
  - `reset` takes priority over a simultaneous write; that write is lost.
  - The ALU and decoder are unaffected by reset.

## Timing
- Read latency is 0 cycles (combinational from `raddr*`).
- Write latency is 1 edge: data is visible on the read ports after the rising edge on which `wen`=1.
- Read-during-write to the same index in the same cycle returns the **old** value, unless `RF_WRITE_BYPASS_EN` is defined.
- Reset values:
  - After reset, `rdata1` and `rdata2` read 0 for every address.
  - `alu_result` and `funct3_d` track their inputs immediately, with no reset value.
- Reset asserted mid-sequence: the clear completes on that edge. A write on the next non-reset edge proceeds normally.
- There is no handshake and no stall; every input is sampled or evaluated every cycle.

## Configuration
- Macro: `RF_WRITE_BYPASS_EN`.
- **Defined:**
  - If `wen`=1, `waddr`≠0 and `raddr1`==`waddr`, then `rdata1` = `wdata` combinationally in the same cycle.
  - `rdata2` behaves the same way against `raddr2`.
  - x0 is never bypassed.
- **Undefined:** no bypass; reads always return stored contents, i.e. the old value on read-during-write.

## Test plan
- **Reset clear:** pre-write x5=0x12345678, assert `reset` for one edge → `rdata1`=0 for `raddr1`=5; sweep all 32 addresses → all read 0.
- **Write/read and x0:**
  - `wen`=1, `waddr`=10, `wdata`=0xDEADBEEF, then on the next cycle `raddr1`=`raddr2`=10 → both read 0xDEADBEEF.
  - Write 0xFFFFFFFF to x0 → `rdata1`=0 for `raddr1`=0.
- **Write disable and reset priority:**
  - `wen`=0 with `waddr`=3, `wdata`=7 → x3 stays at its prior value.
  - `wen`=1 with `reset`=1 on the same edge → x3 reads 0.
- **Read-during-write:** x7=1, then in one cycle `wen`=1, `waddr`=7, `wdata`=2, `raddr1`=7 → `rdata1`=1 before the edge without the macro, 2 with `RF_WRITE_BYPASS_EN`; after the edge → 2 in both builds.
- **ALU:**
  - `alu_op`=1, 0x80000000 + 0xFFFFFFFC → 0x7FFFFFFC.
  - `alu_op`=1, 0xFFFFFFFF + 1 → 0x00000000.
  - `alu_op`=0 → 0x00000000 for any operands.
- **Decoder:** sweep `funct3` 0..7 → `funct3_d` = 0x01, 0x02, 0x04, 0x08, 0x10, 0x20, 0x40, 0x80 respectively.
